tb_mem_splitter: RTL and testbench
==================================

TB_MEM_SPLITTER -- requirements
Module: tb_mem_splitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the word width; only 64 is supported.
REQ-002 SHALL have parameter NUM_WORDS, default 32768, the SRAM depth in 64-bit words.
REQ-003 SHALL have parameter SRAM_BASE, default 64'h0, the SRAM byte base address.
REQ-004 SHALL have parameter MMIO_BASE, default 64'h1100_0000, the MMIO byte base address.
REQ-005 SHALL have parameter NUM_REGS, default 16, the number of 32-bit scratch registers; it is even and at most 512.
REQ-006 SHALL have port clk_i, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit, reset; synchronous, active-high.
REQ-008 SHALL have port req_i, input, 1 bit, upstream word request from axi2mem.
REQ-009 SHALL have port we_i, input, 1 bit, write enable.
REQ-010 SHALL have port addr_i, input, 64 bits, byte address.
REQ-011 SHALL have port be_i, input, 8 bits, byte enables.
REQ-012 SHALL have port wdata_i, input, 64 bits, write data.
REQ-013 SHALL have port rdata_o, output, 64 bits, read data.
REQ-014 SHALL have ports sram_req_o, sram_we_o (1 bit each), sram_addr_o ($clog2(NUM_WORDS) bits), sram_be_o (8), sram_wdata_o (64), all outputs, plus sram_rdata_i, input, 64 bits; this is the tb_sram port.
REQ-015 SHALL have port exit_valid_o, output, 1 bit, sticky flag meaning the program has written the exit register.
REQ-016 SHALL have port exit_code_o, output, 32 bits, the exit value.
REQ-017 SHALL have port unmapped_cnt_o, output, 16 bits, the count of unmapped accesses.

Function
REQ-018 SHALL decode each req_i cycle into exactly one region:
- SRAM: SRAM_BASE <= addr_i < SRAM_BASE + 8*NUM_WORDS.
- REGS: MMIO_BASE <= addr_i < MMIO_BASE + 4*NUM_REGS.
- EXIT: addr_i[63:3] == (MMIO_BASE + 0x4000) >> 3.
- CYCLE: addr_i[63:3] == (MMIO_BASE + 0x4008) >> 3.
- UNMAPPED: anything else.
REQ-019 SHALL make SRAM outputs combinational:
- sram_req_o = req_i AND region SRAM;
- sram_addr_o = (addr_i - SRAM_BASE)[..:3];
- we, be and wdata pass through unchanged.
REQ-020 SHALL perform a REGS write as follows, with word index k = (addr_i - MMIO_BASE) >> 3:
- be_i[3:0] byte-write reg[2k];
- be_i[7:4] byte-write reg[2k+1].
REQ-021 SHALL return {reg[2k+1], reg[2k]} for a REGS read, sampled at the request edge.
REQ-022 SHALL have every region return read data exactly 1 cycle after the req_i cycle, matching SRAM latency.
REQ-023 SHALL hold the read region in a registered select (rsel_q); rdata_o muxes sram_rdata_i or the registered MMIO data.
REQ-024 SHALL handle an EXIT write with be_i[0] set and exit_valid_o low by setting exit_valid_o and loading exit_code_o = wdata_i[31:0]; later EXIT writes are ignored (first write wins).
REQ-025 SHALL return {31'b0, exit_valid_o, exit_code_o} for an EXIT read.
REQ-026 SHALL keep a free-running 64-bit counter cyc_q, incremented every cycle out of reset; a CYCLE read returns the value at the request edge, and CYCLE writes are ignored.
REQ-027 SHALL handle UNMAPPED accesses as follows:
- writes are dropped;
- reads return 64'hDEAD_BEEF_DEAD_BEEF;
- unmapped_cnt_o increments, saturating at 16'hFFFF.
REQ-028 SHALL hold rdata_o at its last value when there is no read in the previous cycle.
REQ-029 SHALL make back-to-back requests every cycle fully pipelined, with no stall; a read following a write to the same REGS word returns the new data.
REQ-030 SHALL let a write to a REGS word and a counter wrap in the same cycle both take effect.

Reset
REQ-031 SHALL, when rst_i is high at a clock edge, clear the following:
- all regs;
- cyc_q;
- exit_valid_o and exit_code_o;
- unmapped_cnt_o;
- rsel_q, which is set to SRAM;
- rdata_o, via its register.
REQ-032 SHALL force sram_req_o low while rst_i is high; a request issued in the reset cycle is discarded and returns no response.
REQ-033 SHALL leave SRAM contents unaffected by rst_i.

Structure
REQ-034 SHALL place the region enum (SRAM, REGS, EXIT, CYCLE, UNMAPPED), the EXIT/CYCLE offsets (0x4000, 0x4008) and the UNMAPPED read pattern in package tb_mem_pkg.
REQ-035 SHALL implement the scratch register file, byte-write and read-sample logic in sub-module tb_mmio_regs; decode, exit, counter and muxing stay in tb_mem_splitter.

Verification
REQ-036 SHALL cover: write 32'h0000_0539 to MMIO_BASE+0x4 (be=8'hF0, wdata[63:32]=0x539) then read MMIO_BASE -> rdata_o = 64'h0000_0539_0000_0000 one cycle after the read.
REQ-037 SHALL cover: write 1 to MMIO_BASE+0x4000, then write 7 -> exit_valid_o=1 and exit_code_o=1 one cycle after the first write, unchanged after the second.
REQ-038 SHALL cover: read 0x8000_0000 -> rdata_o = 64'hDEAD_BEEF_DEAD_BEEF and unmapped_cnt_o = 1; no sram_req_o.
REQ-039 SHALL cover: read word 78 at SRAM_BASE+0x270 -> sram_addr_o = 78 and rdata_o = sram_rdata_i one cycle later.
REQ-040 SHALL cover: deassert rst_i, then read CYCLE at the 10th edge after reset -> rdata_o = 64'd9.
REQ-041 SHALL cover: alternate SRAM read, REGS read and EXIT read on consecutive cycles -> each response in order, one cycle late, none dropped.

Source files
------------

// File: rtl/tb_mem_pkg.sv
// Shared definitions for the testbench memory splitter: address regions,
// fixed MMIO offsets and the read pattern returned for unmapped addresses.
package tb_mem_pkg;

    typedef enum logic [2:0] {
        RGN_SRAM,
        RGN_REGS,
        RGN_EXIT,
        RGN_CYCLE,
        RGN_UNMAPPED
    } region_e;

    localparam logic [63:0] EXIT_OFFSET    = 64'h4000;
    localparam logic [63:0] CYCLE_OFFSET   = 64'h4008;
    localparam logic [63:0] UNMAPPED_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

    function automatic logic word_match(input logic [63:0] addr, input logic [63:0] target);
        return addr[63:3] == target[63:3];
    endfunction

endpackage

// File: rtl/tb_mmio_regs.sv
// Scratch register file seen as NUM_REGS/2 64-bit words, stored as eight byte
// lanes so each byte enable writes its own lane; reads are registered.
module tb_mmio_regs #(
    parameter int NUM_REGS   = 16,
    parameter int NUM_RWORDS = NUM_REGS / 2,
    parameter int IW         = (NUM_RWORDS > 1) ? $clog2(NUM_RWORDS) : 1
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic [IW-1:0] idx_i,
    input  logic [7:0]    be_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] lane_q [NUM_RWORDS];
        logic [7:0] lane_rd_q;

        // Read samples the pre-write contents at the request edge.
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                for (int i = 0; i < NUM_RWORDS; i++) begin
                    lane_q[i] <= '0;
                end
                lane_rd_q <= '0;
            end else begin
                if (wr_i && be_i[gi]) begin
                    lane_q[idx_i] <= wdata_i[8*gi +: 8];
                end
                if (rd_i) begin
                    lane_rd_q <= lane_q[idx_i];
                end
            end
        end

        assign rdata_o[8*gi +: 8] = lane_rd_q;
    end

endmodule

// File: rtl/tb_mem_splitter.sv
// Splits the axi2mem word port into SRAM, scratch registers, exit register,
// cycle counter and an unmapped sink, all answering with one cycle of latency.
module tb_mem_splitter
    import tb_mem_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          NUM_WORDS  = 32768,
    parameter logic [63:0] SRAM_BASE  = 64'h0,
    parameter logic [63:0] MMIO_BASE  = 64'h1100_0000,
    parameter int          NUM_REGS   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [63:0]                  addr_i,
    input  logic [7:0]                   be_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
    output logic [7:0]                   sram_be_o,
    output logic [DATA_WIDTH-1:0]        sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]        sram_rdata_i,
    output logic                         exit_valid_o,
    output logic [31:0]                  exit_code_o,
    output logic [15:0]                  unmapped_cnt_o
);

    localparam int          AW         = $clog2(NUM_WORDS);
    localparam int          NUM_RWORDS = NUM_REGS / 2;
    localparam int          IW         = (NUM_RWORDS > 1) ? $clog2(NUM_RWORDS) : 1;
    localparam logic [63:0] SRAM_BYTES = 64'(NUM_WORDS) << 3;
    localparam logic [63:0] REGS_BYTES = 64'(NUM_REGS) << 2;

    logic [63:0] sram_off;
    logic [63:0] regs_off;
    region_e     region;
    logic        req_ok;
    logic        rd_req;
    logic        wr_req;
    logic [63:0] regs_rdata;
    logic [63:0] rdata_mux;

    logic        rvalid_q, rvalid_d;
    region_e     rsel_q, rsel_d;
    logic [63:0] mmio_q, mmio_d;
    logic [63:0] rdata_q, rdata_d;
    logic        exit_valid_q, exit_valid_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [15:0] unmapped_cnt_q, unmapped_cnt_d;
    logic [63:0] cyc_q, cyc_d;

    // Offsets wrap below the base, so one unsigned compare bounds each window.
    always_comb begin
        sram_off = addr_i - SRAM_BASE;
        regs_off = addr_i - MMIO_BASE;
        region   = RGN_UNMAPPED;
        if (sram_off < SRAM_BYTES) begin
            region = RGN_SRAM;
        end else if (regs_off < REGS_BYTES) begin
            region = RGN_REGS;
        end else if (word_match(addr_i, MMIO_BASE + EXIT_OFFSET)) begin
            region = RGN_EXIT;
        end else if (word_match(addr_i, MMIO_BASE + CYCLE_OFFSET)) begin
            region = RGN_CYCLE;
        end
    end

    assign req_ok = req_i && !rst_i;
    assign rd_req = req_ok && !we_i;
    assign wr_req = req_ok && we_i;

    assign sram_req_o   = req_ok && (region == RGN_SRAM);
    assign sram_we_o    = we_i;
    assign sram_addr_o  = sram_off[AW+2:3];
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;

    tb_mmio_regs #(
        .NUM_REGS (NUM_REGS)
    ) u_regs (
        .clk_i   (clk_i),
        .srst_i  (rst_i),
        .wr_i    (wr_req && (region == RGN_REGS)),
        .rd_i    (rd_req && (region == RGN_REGS)),
        .idx_i   (regs_off[IW+2:3]),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rdata_o (regs_rdata)
    );

    always_comb begin
        case (rsel_q)
            RGN_SRAM: rdata_mux = sram_rdata_i;
            RGN_REGS: rdata_mux = regs_rdata;
            default:  rdata_mux = mmio_q;
        endcase
    end

    assign rdata_o = rvalid_q ? rdata_mux : rdata_q;

    always_comb begin
        cyc_d          = cyc_q + 64'd1;
        rvalid_d       = rd_req;
        rsel_d         = rd_req ? region : rsel_q;
        mmio_d         = mmio_q;
        rdata_d        = rdata_o;
        exit_valid_d   = exit_valid_q;
        exit_code_d    = exit_code_q;
        unmapped_cnt_d = unmapped_cnt_q;
        if (rd_req) begin
            case (region)
                RGN_EXIT:     mmio_d = {31'b0, exit_valid_q, exit_code_q};
                RGN_CYCLE:    mmio_d = cyc_q;
                RGN_UNMAPPED: mmio_d = UNMAPPED_RDATA;
                default:      mmio_d = mmio_q;
            endcase
        end
        if (wr_req && (region == RGN_EXIT) && be_i[0] && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_code_d  = wdata_i[31:0];
        end
        if (req_ok && (region == RGN_UNMAPPED) && (unmapped_cnt_q != 16'hFFFF)) begin
            unmapped_cnt_d = unmapped_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q          <= '0;
            rvalid_q       <= 1'b0;
            rsel_q         <= RGN_SRAM;
            mmio_q         <= '0;
            rdata_q        <= '0;
            exit_valid_q   <= 1'b0;
            exit_code_q    <= '0;
            unmapped_cnt_q <= '0;
        end else begin
            cyc_q          <= cyc_d;
            rvalid_q       <= rvalid_d;
            rsel_q         <= rsel_d;
            mmio_q         <= mmio_d;
            rdata_q        <= rdata_d;
            exit_valid_q   <= exit_valid_d;
            exit_code_q    <= exit_code_d;
            unmapped_cnt_q <= unmapped_cnt_d;
        end
    end

    assign exit_valid_o   = exit_valid_q;
    assign exit_code_o    = exit_code_q;
    assign unmapped_cnt_o = unmapped_cnt_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{sram_off[63:AW+3], sram_off[2:0], regs_off[63:IW+3], regs_off[2:0]};

endmodule

// File: tb/tb_tb_mem_splitter.sv
// Directed bench for tb_mem_splitter: reset, cycle counter, scratch registers,
// exit register, unmapped sink, SRAM pass-through and pipelined reads.
module tb_tb_mem_splitter;

    localparam logic [63:0] MMIO   = 64'h1100_0000;
    localparam logic [63:0] EXIT_A = MMIO + 64'h4000;
    localparam logic [63:0] CYC_A  = MMIO + 64'h4008;
    localparam logic [63:0] DEAD   = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] REG0   = 64'h0000_0539_0000_0000;
    localparam logic [63:0] EXITRD = 64'h0000_0001_0000_0001;
    localparam logic [63:0] SRAM78 = 64'hCAFE_0000_0000_004E;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [14:0] sram_addr_o;
    logic [7:0]  sram_be_o;
    logic [63:0] sram_wdata_o;
    logic [63:0] sram_rdata_i = 64'h0;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;
    logic [15:0] unmapped_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic done = 1'b0;

    always #5 clk_i = ~clk_i;

    // Read-only SRAM stand-in: each word holds a tag plus its own index.
    always @(posedge clk_i) begin
        if (sram_req_o && !sram_we_o) begin
            sram_rdata_i <= {32'hCAFE_0000, 17'b0, sram_addr_o};
        end
    end

    tb_mem_splitter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .we_i           (we_i),
        .addr_i         (addr_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .rdata_o        (rdata_o),
        .sram_req_o     (sram_req_o),
        .sram_we_o      (sram_we_o),
        .sram_addr_o    (sram_addr_o),
        .sram_be_o      (sram_be_o),
        .sram_wdata_o   (sram_wdata_o),
        .sram_rdata_i   (sram_rdata_i),
        .exit_valid_o   (exit_valid_o),
        .exit_code_o    (exit_code_o),
        .unmapped_cnt_o (unmapped_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [63:0] a,
                         input logic [7:0] b, input logic [63:0] d);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        be_i    = b;
        wdata_i = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    endtask

    initial begin
        #100000;
        if (!done) begin
            n_fail++;
            $error("FAIL timeout: stimulus did not complete");
            $finish;
        end
    end

    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        drive(1'b1, 1'b0, 64'h0, 8'hFF, 64'h0);
        check("rst_sram_gate", sram_req_o, 1'b0);
        tick();
        idle();
        check("rst_rdata", rdata_o, 64'h0);
        check("rst_exit_valid", exit_valid_o, 1'b0);
        check("rst_exit_code", exit_code_o, 32'h0);
        check("rst_unmapped", unmapped_cnt_o, 16'h0);

        rst_i = 1'b0;
        repeat (9) tick();
        check("rst_req_dropped", rdata_o, 64'h0);
        drive(1'b1, 1'b0, CYC_A, 8'hFF, 64'h0);
        tick();
        $display("[TB] cycle read -> %0h", rdata_o);
        check("cycle_read", rdata_o, 64'd9);

        drive(1'b1, 1'b1, MMIO + 64'h4, 8'hF0, {32'h0000_0539, 32'hFFFF_FFFF});
        tick();
        drive(1'b1, 1'b0, MMIO, 8'hFF, 64'h0);
        tick();
        $display("[TB] regs read word0 -> %0h", rdata_o);
        check("regs_wr_rd", rdata_o, REG0);
        idle();
        tick();
        check("rdata_hold", rdata_o, REG0);

        drive(1'b1, 1'b1, MMIO + 64'h8, 8'hFF, 64'h1122_3344_5566_7788);
        tick();
        drive(1'b1, 1'b1, MMIO + 64'h8, 8'h01, 64'hFFFF_FFFF_FFFF_FFAA);
        tick();
        drive(1'b1, 1'b0, MMIO + 64'h8, 8'hFF, 64'h0);
        tick();
        $display("[TB] regs read word1 -> %0h", rdata_o);
        check("regs_byte_we", rdata_o, 64'h1122_3344_5566_77AA);

        drive(1'b1, 1'b1, MMIO + 64'h38, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);
        tick();
        drive(1'b1, 1'b0, MMIO + 64'h3C, 8'hFF, 64'h0);
        tick();
        $display("[TB] regs read top word -> %0h", rdata_o);
        check("regs_top_word", rdata_o, 64'hA5A5_5A5A_0F0F_F0F0);

        drive(1'b1, 1'b1, EXIT_A, 8'hFE, 64'h5);
        tick();
        check("exit_no_be0", exit_valid_o, 1'b0);
        drive(1'b1, 1'b1, EXIT_A, 8'h01, 64'h1);
        tick();
        $display("[TB] exit write 1 -> valid %0b code %0h", exit_valid_o, exit_code_o);
        check("exit_valid_set", exit_valid_o, 1'b1);
        check("exit_code_first", exit_code_o, 32'h1);
        drive(1'b1, 1'b1, EXIT_A, 8'h01, 64'h7);
        tick();
        $display("[TB] exit write 7 -> valid %0b code %0h", exit_valid_o, exit_code_o);
        check("exit_code_kept", exit_code_o, 32'h1);
        check("exit_valid_kept", exit_valid_o, 1'b1);
        drive(1'b1, 1'b0, EXIT_A, 8'hFF, 64'h0);
        tick();
        check("exit_read", rdata_o, EXITRD);

        drive(1'b1, 1'b0, 64'h8000_0000, 8'hFF, 64'h0);
        check("unmapped_no_sram", sram_req_o, 1'b0);
        tick();
        $display("[TB] unmapped read -> %0h cnt %0d", rdata_o, unmapped_cnt_o);
        check("unmapped_rdata", rdata_o, DEAD);
        check("unmapped_cnt1", unmapped_cnt_o, 16'd1);
        drive(1'b1, 1'b1, 64'h8000_0000, 8'hFF, 64'h123);
        tick();
        check("unmapped_cnt2", unmapped_cnt_o, 16'd2);
        drive(1'b1, 1'b0, MMIO, 8'hFF, 64'h0);
        tick();
        check("regs_reread", rdata_o, REG0);
        drive(1'b1, 1'b0, MMIO + 64'h40, 8'hFF, 64'h0);
        tick();
        $display("[TB] read past regs -> %0h cnt %0d", rdata_o, unmapped_cnt_o);
        check("regs_end_rdata", rdata_o, DEAD);
        check("unmapped_cnt3", unmapped_cnt_o, 16'd3);

        drive(1'b1, 1'b0, 64'h270, 8'hFF, 64'h0);
        check("sram_req_78", sram_req_o, 1'b1);
        check("sram_addr_78", sram_addr_o, 15'd78);
        tick();
        $display("[TB] sram read word 78 -> %0h", rdata_o);
        check("sram_rdata_78", rdata_o, SRAM78);
        drive(1'b1, 1'b0, 64'h3_FFF8, 8'hFF, 64'h0);
        check("sram_req_last", sram_req_o, 1'b1);
        check("sram_addr_last", sram_addr_o, 15'd32767);
        tick();
        check("sram_rdata_last", rdata_o, 64'hCAFE_0000_0000_7FFF);
        drive(1'b1, 1'b0, 64'h4_0000, 8'hFF, 64'h0);
        check("sram_end_no_req", sram_req_o, 1'b0);
        tick();
        check("sram_end_rdata", rdata_o, DEAD);
        check("unmapped_cnt4", unmapped_cnt_o, 16'd4);
        drive(1'b1, 1'b1, 64'h10, 8'h5A, 64'h0123_4567_89AB_CDEF);
        check("sram_we_pass", sram_we_o, 1'b1);
        check("sram_be_pass", sram_be_o, 8'h5A);
        check("sram_wdata_pass", sram_wdata_o, 64'h0123_4567_89AB_CDEF);
        check("sram_addr_wr", sram_addr_o, 15'd2);
        tick();

        drive(1'b1, 1'b0, 64'h270, 8'hFF, 64'h0);
        tick();
        check("pipe_sram", rdata_o, SRAM78);
        drive(1'b1, 1'b0, MMIO, 8'hFF, 64'h0);
        tick();
        check("pipe_regs", rdata_o, REG0);
        drive(1'b1, 1'b0, EXIT_A, 8'hFF, 64'h0);
        tick();
        check("pipe_exit", rdata_o, EXITRD);
        idle();
        tick();
        check("pipe_hold", rdata_o, EXITRD);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
